risc_v_processor: RTL and testbench

//  Single-cycle RV64 subset core: one instruction fetched, decoded, executed and retired per clk.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/risc_v_processor_alu64.sv | 27 ++
 rtl/risc_v_processor.sv | 186 ++++++++++++++++++
 tb/tb_risc_v_processor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the single-cycle RV64 subset core: opcodes, ALUOp, ALU operations, field offsets.
// Latency: n/a (constants only). Backpressure: none.
// Consumers: risc_v_processor and alu64.
package riscv_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110
  } alu_op_e;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/risc_v_processor_alu64.sv
// 64-bit ALU: AND/OR/ADD/SUB with zero flag; arithmetic wraps modulo 2^64.
// Latency: combinational. Backpressure: none.
// Unknown operation codes yield zero.
module alu64
  import riscv_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  Operation,
  output logic [63:0] Result,
  output logic        ZERO
);

  always_comb begin
    Result = 64'd0;
    case (Operation)
      OP_AND:  Result = a & b;
      OP_OR:   Result = a | b;
      OP_ADD:  Result = a + b;
      OP_SUB:  Result = a - b;
      default: Result = 64'd0;
    endcase
  end

  assign ZERO = (Result == 64'd0);

endmodule

// File: rtl/risc_v_processor.sv
// Single-cycle RV64 subset core with boot ROM, register file and data RAM; all internal nets exported.
// Latency: one instruction retired per clk; reads combinational, writes on posedge clk.
// Backpressure: none; the core never stalls.
module risc_v_processor
  import riscv_pkg::*;
#(
  parameter int IMEM_BYTES = 64,
  parameter int DMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] PC_Out,
  output logic [63:0] PC_In,
  output logic [31:0] Instruction,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2,
  output logic [63:0] imm_data,
  output logic [63:0] Mux2Out,
  output logic [63:0] Result,
  output logic        ZERO,
  output logic [63:0] Read_Data,
  output logic [63:0] WriteData,
  output logic [63:0] Adder1Out,
  output logic [63:0] Adder2Out,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic [3:0]  Operation,
  output logic [63:0] val1,
  output logic [63:0] val2,
  output logic [63:0] val3,
  output logic [63:0] val4
);

  localparam int IMEM_AW    = $clog2(IMEM_BYTES);
  localparam int DMEM_AW    = $clog2(DMEM_BYTES);
  localparam int DMEM_WORDS = DMEM_BYTES / 8;

  logic [63:0] regs [32];
  logic [63:0] dmem [DMEM_WORDS];
  logic [IMEM_AW-3:0] imem_idx;
  logic [DMEM_AW-4:0] dmem_idx;
  logic [31:0] rom_word;
  alu_op_e     alu_op;

  // Boot ROM; indices past the program read as 0, which decodes as unsupported.
  assign imem_idx = PC_Out[IMEM_AW-1:2];
  assign rom_word = 32'(imem_idx);
  always_comb begin
    Instruction = 32'h0000_0000;
    case (rom_word)
      32'd0:   Instruction = 32'h0050_0093; // addi x1,x0,5
      32'd1:   Instruction = 32'h0070_0113; // addi x2,x0,7
      32'd2:   Instruction = 32'h0020_81B3; // add  x3,x1,x2
      32'd3:   Instruction = 32'h4011_0233; // sub  x4,x2,x1
      32'd4:   Instruction = 32'h0030_3023; // sd   x3,0(x0)
      32'd5:   Instruction = 32'h0040_3423; // sd   x4,8(x0)
      32'd6:   Instruction = 32'h0000_3283; // ld   x5,0(x0)
      32'd7:   Instruction = 32'h0020_F333; // and  x6,x1,x2
      32'd8:   Instruction = 32'h0020_E3B3; // or   x7,x1,x2
      32'd9:   Instruction = 32'h0060_3823; // sd   x6,16(x0)
      32'd10:  Instruction = 32'h0070_3C23; // sd   x7,24(x0)
      32'd11:  Instruction = 32'h0000_0063; // beq  x0,x0,0
      default: Instruction = 32'h0000_0000;
    endcase
  end

  assign opcode = Instruction[OPCODE_LSB +: 7];
  assign rd     = Instruction[RD_LSB     +: 5];
  assign funct3 = Instruction[FUNCT3_LSB +: 3];
  assign rs1    = Instruction[RS1_LSB    +: 5];
  assign rs2    = Instruction[RS2_LSB    +: 5];
  assign funct7 = Instruction[FUNCT7_LSB +: 7];

  always_comb begin
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = ALUOP_ADD;
    imm_data = 64'd0;
    case (opcode)
      OPC_RTYPE: begin
        RegWrite = 1'b1;
        ALUOp    = ALUOP_RTYPE;
      end
      OPC_ADDI: begin
        ALUSrc   = 1'b1;
        RegWrite = 1'b1;
        imm_data = {{52{Instruction[31]}}, Instruction[31:20]};
      end
      OPC_LOAD: begin
        ALUSrc   = 1'b1;
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        imm_data = {{52{Instruction[31]}}, Instruction[31:20]};
      end
      OPC_STORE: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
        imm_data = {{52{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
      end
      OPC_BRANCH: begin
        Branch   = 1'b1;
        ALUOp    = ALUOP_BEQ;
        // Half-offset: the adder shifts it left by one.
        imm_data = {{52{Instruction[31]}}, Instruction[31], Instruction[7],
                    Instruction[30:25], Instruction[11:8]};
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_op = OP_ADD;
    case (ALUOp)
      ALUOP_BEQ: alu_op = OP_SUB;
      ALUOP_RTYPE: begin
        case ({funct7[5], funct3})
          4'b1000: alu_op = OP_SUB;
          4'b0111: alu_op = OP_AND;
          4'b0110: alu_op = OP_OR;
          default: alu_op = OP_ADD;
        endcase
      end
      default: alu_op = OP_ADD;
    endcase
  end
  assign Operation = alu_op;

  assign ReadData1 = (rs1 == 5'd0) ? 64'd0 : regs[rs1];
  assign ReadData2 = (rs2 == 5'd0) ? 64'd0 : regs[rs2];
  assign Mux2Out   = ALUSrc ? imm_data : ReadData2;

  alu64 u_alu (
    .a         (ReadData1),
    .b         (Mux2Out),
    .Operation (Operation),
    .Result    (Result),
    .ZERO      (ZERO)
  );

  assign dmem_idx  = Result[DMEM_AW-1:3];
  assign Read_Data = MemRead ? dmem[dmem_idx] : 64'd0;
  assign WriteData = MemtoReg ? Read_Data : Result;
  assign Adder1Out = PC_Out + 64'd4;
  assign Adder2Out = PC_Out + (imm_data << 1);
  assign PC_In     = (Branch & ZERO) ? Adder2Out : Adder1Out;

  assign val1 = dmem[0];
  assign val2 = dmem[1];
  assign val3 = dmem[2];
  assign val4 = dmem[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_Out <= 64'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else begin
      PC_Out <= {PC_In[63:IMEM_AW], PC_In[IMEM_AW-1:0]};
      if (RegWrite && rd != 5'd0) regs[rd] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 64'd0;
    end else if (MemWrite) begin
      dmem[dmem_idx] <= ReadData2;
    end
  end

endmodule

// File: tb/tb_risc_v_processor.sv
// Self-checking bench for risc_v_processor: per-cycle scoreboard of PC/Result/WriteData over the boot program,
// plus spot checks of control, reset state, branch self-loop and mid-run reset.
module tb_risc_v_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] PC_Out, PC_In, ReadData1, ReadData2, imm_data, Mux2Out, Result;
  logic [63:0] Read_Data, WriteData, Adder1Out, Adder2Out, val1, val2, val3, val4;
  logic [31:0] Instruction;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        ZERO, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [1:0]  ALUOp;
  logic [3:0]  Operation;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] res;
    logic [63:0] wd;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  risc_v_processor dut (
    .clk(clk), .reset(reset), .PC_Out(PC_Out), .PC_In(PC_In), .Instruction(Instruction),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .imm_data(imm_data), .Mux2Out(Mux2Out),
    .Result(Result), .ZERO(ZERO), .Read_Data(Read_Data), .WriteData(WriteData),
    .Adder1Out(Adder1Out), .Adder2Out(Adder2Out), .Branch(Branch), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .Operation(Operation), .val1(val1), .val2(val2), .val3(val3), .val4(val4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Hand-derived retire results of the boot program, one row per instruction.
  function automatic exp_t golden(input int i);
    exp_t e;
    e.pc = 64'(4 * i);
    case (i)
      0:  begin e.res = 64'd5;  e.wd = 64'd5;  end
      1:  begin e.res = 64'd7;  e.wd = 64'd7;  end
      2:  begin e.res = 64'd12; e.wd = 64'd12; end
      3:  begin e.res = 64'd2;  e.wd = 64'd2;  end
      4:  begin e.res = 64'd0;  e.wd = 64'd0;  end
      5:  begin e.res = 64'd8;  e.wd = 64'd8;  end
      6:  begin e.res = 64'd0;  e.wd = 64'd12; end
      7:  begin e.res = 64'd5;  e.wd = 64'd5;  end
      8:  begin e.res = 64'd7;  e.wd = 64'd7;  end
      9:  begin e.res = 64'd16; e.wd = 64'd16; end
      10: begin e.res = 64'd24; e.wd = 64'd24; end
      default: begin e.res = 64'd0; e.wd = 64'd0; end
    endcase
    return e;
  endfunction

  // Called on a negedge just after reset release; ends on a negedge with PC parked at 44.
  task automatic run_program();
    exp_t e;
    for (int i = 0; i < 12; i++) sb_q.push_back(golden(i));
    for (int i = 0; i < 12; i++) begin
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("pc[%0d]", i), PC_Out, e.pc);
        check($sformatf("result[%0d]", i), Result, e.res);
        check($sformatf("writedata[%0d]", i), WriteData, e.wd);
      end
      case (i)
        2: begin
          check("add_rd1", ReadData1, 64'd5);
          check("add_rd2", ReadData2, 64'd7);
          check("add_op", 64'(Operation), 64'b0010);
          check("add_adder1", Adder1Out, 64'd12);
        end
        3: check("sub_op", 64'(Operation), 64'b0110);
        6: begin
          check("sd_val1", val1, 64'd12);
          check("sd_val2", val2, 64'd2);
          check("ld_memread", 64'(MemRead), 64'd1);
          check("ld_memtoreg", 64'(MemtoReg), 64'd1);
          check("ld_readdata", Read_Data, 64'd12);
        end
        11: begin
          check("sd_val3", val3, 64'd5);
          check("sd_val4", val4, 64'd7);
          check("beq_branch", 64'(Branch), 64'd1);
          check("beq_zero", 64'(ZERO), 64'd1);
          check("beq_adder2", Adder2Out, 64'd44);
          check("beq_pcin", PC_In, 64'd44);
        end
        default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #100;
    check("rst_pc", PC_Out, 64'd0);
    check("rst_inst", 64'(Instruction), 64'h0050_0093);
    check("rst_imm", imm_data, 64'd5);
    check("rst_regwrite", 64'(RegWrite), 64'd1);
    check("rst_alusrc", 64'(ALUSrc), 64'd1);
    check("rst_val1", val1, 64'd0);
    check("rst_val2", val2, 64'd0);
    check("rst_val3", val3, 64'd0);
    check("rst_val4", val4, 64'd0);
    reset = 1'b0;

    run_program();
    for (int c = 0; c < 12; c++) begin
      check("loop_pc", PC_Out, 64'd44);
      @(posedge clk);
      @(negedge clk);
    end

    reset = 1'b1;
    #1;
    check("midrst_pc", PC_Out, 64'd0);
    check("midrst_val1", val1, 64'd0);
    check("midrst_val2", val2, 64'd0);
    check("midrst_val3", val3, 64'd0);
    check("midrst_val4", val4, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_program();
    check("rerun_pc", PC_Out, 64'd44);
    check("rerun_val1", val1, 64'd12);
    check("rerun_val2", val2, 64'd2);
    check("rerun_val3", val3, 64'd5);
    check("rerun_val4", val4, 64'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
